// File: rtl/hazard_scoreboard_unit.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard_unit
//
// Hazard controller for a 5-stage RV32I pipeline (F/D/E/M/W). It selects the
// E-stage operand forwarding paths, tracks destination registers of
// long-latency (mul/div) operations that complete out of band, detects
// load-use and scoreboard hazards against the instruction in D, and resolves
// them against branch flushes. Two saturating counters report stall and flush
// activity.
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   Rs1D, Rs2D, RdD            decode-stage source/destination registers
//   Rs1E, Rs2E, RdE            execute-stage source/destination registers
//   RegWriteE/MemReadE/LongOpE E-stage writes rd / is a load / is a long op
//   RdM, RegWriteM             memory-stage destination and write enable
//   RdW, RegWriteW             writeback-stage destination and write enable
//   long_done, long_rd         long unit completes this cycle, and its rd
//   flushBranch                branch mispredict resolved in E
//   ForwardAE, ForwardBE       00 regfile, 01 ResultW, 10 ALUResultM, 11 long
//   StallF/StallD/StallE       hold stage register
//   FlushD/FlushE/FlushM       insert bubble into stage register
//   outstanding                number of in-flight long ops
//   stall_cnt, flush_cnt       saturating performance counters
// -----------------------------------------------------------------------------
module hazard_scoreboard_unit #(
  parameter  int REG_ADDR_WIDTH  = 5,
  parameter  int MAX_OUTSTANDING = 4,
  parameter  int CNT_WIDTH       = 16,
  localparam int NUM_REGS        = 2**REG_ADDR_WIDTH,
  localparam int OUT_WIDTH       = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [REG_ADDR_WIDTH-1:0] Rs1D,
  input  logic [REG_ADDR_WIDTH-1:0] Rs2D,
  input  logic [REG_ADDR_WIDTH-1:0] RdD,
  input  logic [REG_ADDR_WIDTH-1:0] Rs1E,
  input  logic [REG_ADDR_WIDTH-1:0] Rs2E,
  input  logic [REG_ADDR_WIDTH-1:0] RdE,
  input  logic                      RegWriteE,
  input  logic                      MemReadE,
  input  logic                      LongOpE,
  input  logic [REG_ADDR_WIDTH-1:0] RdM,
  input  logic [REG_ADDR_WIDTH-1:0] RdW,
  input  logic                      RegWriteM,
  input  logic                      RegWriteW,
  input  logic                      long_done,
  input  logic [REG_ADDR_WIDTH-1:0] long_rd,
  input  logic                      flushBranch,
  output logic [1:0]                ForwardAE,
  output logic [1:0]                ForwardBE,
  output logic                      StallF,
  output logic                      StallD,
  output logic                      StallE,
  output logic                      FlushD,
  output logic                      FlushE,
  output logic                      FlushM,
  output logic [OUT_WIDTH-1:0]      outstanding,
  output logic [CNT_WIDTH-1:0]      stall_cnt,
  output logic [CNT_WIDTH-1:0]      flush_cnt
);

  localparam logic [OUT_WIDTH-1:0] OUT_MAX = OUT_WIDTH'(MAX_OUTSTANDING);

  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] done_mask;
  logic [NUM_REGS-1:0] issue_mask;
  logic [NUM_REGS-1:0] pend_eff;
  logic                sb_hz, lu_hz, full_hz;
  logic                issue, valid_done;

  // Forwarding select for one E-stage source. M wins because it holds the
  // youngest value; a completing long op beats the older W result.
  function automatic logic [1:0] fwd_sel(
    input logic [REG_ADDR_WIDTH-1:0] rs,
    input logic [REG_ADDR_WIDTH-1:0] rd_m,
    input logic                      we_m,
    input logic                      done,
    input logic [REG_ADDR_WIDTH-1:0] rd_long,
    input logic [REG_ADDR_WIDTH-1:0] rd_w,
    input logic                      we_w
  );
    if (rs == '0)                  return 2'b00;
    else if (we_m && rd_m == rs)   return 2'b10;
    else if (done && rd_long == rs) return 2'b11;
    else if (we_w && rd_w == rs)   return 2'b01;
    else                           return 2'b00;
  endfunction

  assign ForwardAE = fwd_sel(Rs1E, RdM, RegWriteM, long_done, long_rd, RdW, RegWriteW);
  assign ForwardBE = fwd_sel(Rs2E, RdM, RegWriteM, long_done, long_rd, RdW, RegWriteW);

  // One-hot masks for the completing and the issuing register.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    done_mask  = '0;
    issue_mask = '0;
    if (long_done) done_mask[long_rd] = 1'b1;
    if (issue)     issue_mask[RdE]    = 1'b1;
  end

  // A completion in this cycle already releases its register.
  assign pend_eff = pending & ~done_mask;

  assign sb_hz   = pend_eff[Rs1D] | pend_eff[Rs2D] | pend_eff[RdD];
  assign lu_hz   = MemReadE && RegWriteE && (RdE != '0) && (RdE == Rs1D || RdE == Rs2D);
  assign full_hz = LongOpE && RegWriteE && (outstanding == OUT_MAX) && !long_done;

  // Control resolution: branch flush discards everything younger, then a full
  // long unit freezes F/D/E, then D-stage hazards bubble E.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushM = 1'b0;
    if (flushBranch) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (full_hz) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      FlushM = 1'b1;
    end else if (lu_hz || sb_hz) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end
  end

  assign issue      = LongOpE && RegWriteE && (RdE != '0) && !StallE && !FlushE;
  assign valid_done = long_done && pending[long_rd];

  // Scoreboard: clear on completion, set on issue (set wins on collision).
  // x0 never becomes pending.
  // NOTE: the pending vector is state that must read "nothing in flight"
  // after reset, so unlike a datapath memory it is reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values.
      pending <= '0;
    end else begin
      pending <= ((pending & ~done_mask) | issue_mask) & ~NUM_REGS'(1);
    end
  end

  // In-flight count; +1 and -1 in the same cycle cancel, and it never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding <= '0;
    end else begin
      unique case ({issue, valid_done})
        2'b10:   if (outstanding != OUT_MAX) outstanding <= outstanding + 1'b1;
        2'b01:   if (outstanding != '0)      outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (StallD && stall_cnt != '1)      stall_cnt <= stall_cnt + 1'b1;
      if (flushBranch && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: doc/hazard_scoreboard_unit.md
Name: hazard_scoreboard_unit

Overview:
- Next-generation hazard controller for the 5-stage RV32I pipeline (F/D/E/M/W).
- Keeps full M/W forwarding to the E stage and adds a per-register scoreboard for long-latency ops (mul/div unit) that complete out of band.
- Detects load-use hazards D-vs-E and resolves branch flushes with defined priorities.
- Holds saturating stall/flush performance counters; sits beside the datapath and drives all stage enable/flush lines.

Parameters:
- REG_ADDR_WIDTH, 5, register index width; register file has 2**REG_ADDR_WIDTH entries.
- MAX_OUTSTANDING, 4, maximum in-flight long ops (1..2**REG_ADDR_WIDTH-1).
- CNT_WIDTH, 16, width of performance counters.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- Rs1D, Rs2D, RdD  in  REG_ADDR_WIDTH  decode-stage source/dest registers
- Rs1E, Rs2E, RdE  in  REG_ADDR_WIDTH  execute-stage source/dest registers
- RegWriteE, MemReadE, LongOpE  in  1  E-stage writes rd / is load / is long op
- RdM, RdW  in  REG_ADDR_WIDTH  memory/writeback destination registers
- RegWriteM, RegWriteW  in  1  M/W write enables
- long_done  in  1  long unit completes this cycle; result on long-result bus
- long_rd  in  REG_ADDR_WIDTH  destination of the completing long op
- flushBranch  in  1  branch mispredict resolved in E
- ForwardAE, ForwardBE  out  2  00 regfile, 01 ResultW, 10 ALUResultM, 11 long result
- StallF, StallD, StallE  out  1  hold stage register
- FlushD, FlushE, FlushM  out  1  insert bubble into stage register
- outstanding  out  $clog2(MAX_OUTSTANDING+1)  in-flight long ops
- stall_cnt, flush_cnt  out  CNT_WIDTH  perf counters

Behaviour:
- Reset (async, rst_n=0): pending vector, outstanding, stall_cnt and flush_cnt cleared to 0 immediately. Combinational outputs follow from the cleared state. Reset mid long-op discards it; a late long_done after reset with pending[long_rd]=0 is ignored.
- Forwarding (combinational, per source, Rs==0 never forwards). Priority:
  - M match (RegWriteM, RdM==Rs): 10
  - else long_done && long_rd==Rs: 11
  - else W match (RegWriteW): 01
  - else 00
  - ForwardBE uses identical logic on Rs2E.
- Scoreboard:
  - pending[r] is set at the clock edge when issue = LongOpE && RegWriteE && RdE!=0 && !StallE && !FlushE.
  - pending[long_rd] is cleared on long_done; pending[0] is always 0.
  - Same-cycle set and clear of the same register: set wins. Outstanding is unchanged in that case (+1 −1).
  - outstanding increments on issue, decrements on a valid done (pending bit was set), and never wraps.
  - pend_eff = pending & ~(long_done ? onehot(long_rd) : 0). A same-cycle completion releases its register.
- Hazard terms:
  - sb_hz = pend_eff[Rs1D] | pend_eff[Rs2D] | pend_eff[RdD]. Covers RAW and WAW; index 0 never hazards.
  - lu_hz = MemReadE && RegWriteE && RdE!=0 && (RdE==Rs1D || RdE==Rs2D).
  - full_hz = LongOpE && RegWriteE && outstanding==MAX_OUTSTANDING && !long_done.
- Control resolution, in priority order:
  1. flushBranch: FlushD=FlushE=1, all stalls 0, FlushM=0. Stalled wrong-path instructions are discarded.
  2. full_hz: StallF=StallD=StallE=1, FlushM=1.
  3. lu_hz or sb_hz: StallF=StallD=1, FlushE=1.
  4. Otherwise all 0.
- Counters:
  - stall_cnt increments on each cycle with StallD=1.
  - flush_cnt increments on each cycle with flushBranch=1.
  - Both saturate at all-ones and do not wrap.
- Latency: all control outputs are combinational from inputs and registered state. Scoreboard and counters update at the clock edge.

Test Plan:
- Forwarding priority: RdM=RdW=5, both write enables, Rs1E=5 -> ForwardAE=10. Deassert RegWriteM -> 01. Rs1E=0 with RdM=0 -> 00.
- Load-use: MemReadE=1, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1 for one cycle; stall_cnt increments 0->1.
- Long-op RAW: issue LongOpE with RdE=9.
  - Next instruction in D has Rs1D=9: StallD held until long_done with long_rd=9.
  - The done cycle itself releases StallD and gives ForwardAE=11 when Rs1E=9.
  - outstanding goes 1->0.
- Outstanding full (MAX_OUTSTANDING=4): issue 4 long ops to x1..x4. A 5th LongOpE gives StallE=FlushM=1 and outstanding stays 4. Assert long_done with long_rd=1 in the same cycle -> stall drops and outstanding stays 4.
- Branch priority: lu_hz active and flushBranch=1 together -> FlushD=FlushE=1, StallF=StallD=0, flush_cnt=1, stall_cnt unchanged.
- Reset mid-operation: 2 pending long ops, pull rst_n low asynchronously mid-cycle -> outstanding=0 and counters 0 immediately. A later long_done is ignored and outstanding stays 0.
